// File: rtl/m6502_mem_responder.sv
// Memory-side responder for the m6502 bus: RAM, vector bytes and open bus,
// with read pacing through ready and a sticky protocol-error flag.
module m6502_mem_responder #(
    parameter int          RAM_BITS     = 12,
    parameter int          WAIT_STATES  = 1,
    parameter logic [15:0] RESET_VECTOR = 16'hF000,
    parameter logic [15:0] NMI_VECTOR   = 16'hF000,
    parameter logic [15:0] IRQ_VECTOR   = 16'hF000,
    parameter logic [7:0]  OPEN_BUS     = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr,
    input  logic        rd_req,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        ready,
    output logic        err,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [7:0]  load_data
);

    localparam int RAM_DEPTH = 1 << RAM_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        state, state_next;
    logic [3:0]    wcnt, wcnt_next;
    logic [15:0]   req_addr, req_addr_next;
    logic [7:0]    rd_data_next;
    logic          ready_next;
    logic          err_next;

    logic [7:0]          ram [0:RAM_DEPTH-1];
    logic [7:0]          ram_q;
    logic                ram_we;
    logic [RAM_BITS-1:0] ram_addr;
    logic [7:0]          ram_wdata;
    logic [7:0]          resp_byte;
    logic                cpu_strobe;

    function automatic logic in_ram(input logic [15:0] a);
        return ~|a[15:RAM_BITS];
    endfunction

    assign cpu_strobe = rd_req | wr_en;

    // ram_q always holds the byte at the address presented on the previous
    // edge; during WAIT that is req_addr, so it is ready when RESP fires.
    always_comb begin
        resp_byte = OPEN_BUS;
        if (in_ram(req_addr)) begin
            resp_byte = ram_q;
        end else if (req_addr >= 16'hFFFA) begin
            case (req_addr[2:0])
                3'b010:  resp_byte = NMI_VECTOR[7:0];
                3'b011:  resp_byte = NMI_VECTOR[15:8];
                3'b100:  resp_byte = RESET_VECTOR[7:0];
                3'b101:  resp_byte = RESET_VECTOR[15:8];
                3'b110:  resp_byte = IRQ_VECTOR[7:0];
                3'b111:  resp_byte = IRQ_VECTOR[15:8];
                default: resp_byte = OPEN_BUS;
            endcase
        end
    end

    always_comb begin
        state_next    = state;
        wcnt_next     = wcnt;
        req_addr_next = req_addr;
        rd_data_next  = rd_data;
        ready_next    = ready;
        err_next      = err;
        ram_we        = 1'b0;
        ram_addr      = addr[RAM_BITS-1:0];
        ram_wdata     = wr_data;

        case (state)
            ST_WAIT: begin
                ram_addr  = req_addr[RAM_BITS-1:0];
                wcnt_next = wcnt - 4'd1;
                if (cpu_strobe) begin
                    err_next = 1'b1;
                end
                if (wcnt == 4'd1) begin
                    state_next = ST_RESP;
                end
            end
            default: begin
                if (state == ST_RESP) begin
                    rd_data_next = resp_byte;
                    ready_next   = 1'b1;
                    state_next   = ST_IDLE;
                end
                // RESP also accepts a fresh strobe so zero-wait reads can stream.
                if (wr_en) begin
                    ram_we = in_ram(addr);
                    if (rd_req) begin
                        err_next = 1'b1;
                    end
                end else if (rd_req) begin
                    req_addr_next = addr;
                    if (WAIT_STATES == 0) begin
                        state_next = ST_RESP;
                    end else begin
                        wcnt_next  = 4'(WAIT_STATES);
                        ready_next = 1'b0;
                        state_next = ST_WAIT;
                    end
                end
            end
        endcase

        if (load_en) begin
            if (state == ST_IDLE && !cpu_strobe) begin
                if (in_ram(load_addr)) begin
                    ram_we    = 1'b1;
                    ram_addr  = load_addr[RAM_BITS-1:0];
                    ram_wdata = load_data;
                end
            end else begin
                err_next = 1'b1;
            end
        end

        if (!reset_n) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            wcnt     <= 4'd0;
            req_addr <= 16'h0000;
            rd_data  <= 8'h00;
            ready    <= 1'b1;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            wcnt     <= wcnt_next;
            req_addr <= req_addr_next;
            rd_data  <= rd_data_next;
            ready    <= ready_next;
            err      <= err_next;
        end
    end

    // Single-port array with read-before-write registered output.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
        ram_q <= ram[ram_addr];
    end

endmodule

// File: tb/tb_m6502_mem_responder.sv
// Self-checking bench: a two-wait-state responder for transactions and error
// cases, and a zero-wait-state one for streaming reads.
module tb_m6502_mem_responder;

    logic        clk;
    logic        reset_n;
    logic [15:0] addr;
    logic [7:0]  wr_data;
    logic        load_en;
    logic [15:0] load_addr;
    logic [7:0]  load_data;

    logic        rd_req_a, wr_en_a;
    logic [7:0]  rd_data_a;
    logic        ready_a, err_a;

    logic        rd_req_b, wr_en_b;
    logic [7:0]  rd_data_b;
    logic        ready_b, err_b;

    int checks = 0;
    int passes = 0;
    logic [7:0] sb[$];

    typedef struct {
        bit          is_wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[12];

    m6502_mem_responder #(.WAIT_STATES(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .addr(addr), .rd_req(rd_req_a),
        .wr_en(wr_en_a), .wr_data(wr_data), .rd_data(rd_data_a),
        .ready(ready_a), .err(err_a), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data)
    );

    m6502_mem_responder #(.WAIT_STATES(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .addr(addr), .rd_req(rd_req_b),
        .wr_en(wr_en_b), .wr_data(wr_data), .rd_data(rd_data_b),
        .ready(ready_b), .err(err_b), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic loadMem(input logic [15:0] a, input logic [7:0] d);
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        @(posedge clk); #1;
        load_en   = 1'b0;
    endtask

    task automatic writeA(input logic [15:0] a, input logic [7:0] d, input string name);
        addr    = a;
        wr_data = d;
        wr_en_a = 1'b1;
        @(posedge clk); #1;
        wr_en_a = 1'b0;
        checkOutput({name, "_ready"}, 32'(ready_a), 32'd1);
    endtask

    // Counts samples with ready low after the strobe edge, bounded.
    task automatic waitReadyA(input int start_low, output int low);
        low = start_low;
        while (!ready_a && low < 20) begin
            low++;
            @(posedge clk); #1;
        end
    endtask

    task automatic readA(input logic [15:0] a, input logic [7:0] exp, input string name);
        int low;
        addr     = a;
        rd_req_a = 1'b1;
        sb.push_back(exp);
        @(posedge clk); #1;
        rd_req_a = 1'b0;
        waitReadyA(0, low);
        checkOutput({name, "_wait"}, 32'(low), 32'd3);
        checkOutput(name, 32'(rd_data_a), 32'(sb.pop_front()));
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        if (v.is_wr) begin
            writeA(v.a, v.d, name);
        end else begin
            readA(v.a, v.exp, name);
        end
    endtask

    initial begin
        int low;
        logic [7:0] exp_b;

        vecs[0]  = '{1'b0, 16'hFFFC, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 16'hFFFD, 8'h00, 8'hF0};
        vecs[2]  = '{1'b1, 16'h0123, 8'h5A, 8'h00};
        vecs[3]  = '{1'b0, 16'h0123, 8'h00, 8'h5A};
        vecs[4]  = '{1'b0, 16'h0124, 8'h00, 8'hA5};
        vecs[5]  = '{1'b1, 16'h8000, 8'h77, 8'h00};
        vecs[6]  = '{1'b0, 16'h8000, 8'h00, 8'hFF};
        vecs[7]  = '{1'b0, 16'h1000, 8'h00, 8'hFF};
        vecs[8]  = '{1'b0, 16'h0FFF, 8'h00, 8'h3C};
        vecs[9]  = '{1'b0, 16'hFFF9, 8'h00, 8'hFF};
        vecs[10] = '{1'b0, 16'hFFFA, 8'h00, 8'h00};
        vecs[11] = '{1'b0, 16'hFFFF, 8'h00, 8'hF0};

        reset_n   = 1'b0;
        addr      = 16'h0000;
        wr_data   = 8'h00;
        load_en   = 1'b0;
        load_addr = 16'h0000;
        load_data = 8'h00;
        rd_req_a  = 1'b0;
        wr_en_a   = 1'b0;
        rd_req_b  = 1'b0;
        wr_en_b   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready_a", 32'(ready_a), 32'd1);
        checkOutput("rst_rd_data_a", 32'(rd_data_a), 32'h00);
        checkOutput("rst_err_a", 32'(err_a), 32'd0);
        checkOutput("rst_ready_b", 32'(ready_b), 32'd1);
        checkOutput("rst_err_b", 32'(err_b), 32'd0);
        reset_n = 1'b1;

        loadMem(16'h0124, 8'hA5);
        loadMem(16'h0FFF, 8'h3C);
        loadMem(16'h0200, 8'hC3);
        for (int i = 0; i < 16; i++) begin
            loadMem(16'(i), 8'(i * 17 + 3));
        end
        checkOutput("load_err_a", 32'(err_a), 32'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end
        checkOutput("table_err", 32'(err_a), 32'd0);

        // Simultaneous read and write: write wins, read discarded, err set.
        addr     = 16'h0010;
        wr_data  = 8'h33;
        rd_req_a = 1'b1;
        wr_en_a  = 1'b1;
        @(posedge clk); #1;
        rd_req_a = 1'b0;
        wr_en_a  = 1'b0;
        checkOutput("rw_ready", 32'(ready_a), 32'd1);
        checkOutput("rw_err", 32'(err_a), 32'd1);
        @(posedge clk); #1;
        checkOutput("rw_ready_idle", 32'(ready_a), 32'd1);
        readA(16'h0010, 8'h33, "rw_readback");

        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checkOutput("rst2_err", 32'(err_a), 32'd0);
        checkOutput("rst2_rd_data", 32'(rd_data_a), 32'h00);

        // Strobe during WAIT is ignored; original read completes.
        addr     = 16'h0200;
        rd_req_a = 1'b1;
        sb.push_back(8'hC3);
        @(posedge clk); #1;
        addr     = 16'h0300;
        checkOutput("wait_strobe_low", 32'(ready_a), 32'd0);
        @(posedge clk); #1;
        rd_req_a = 1'b0;
        checkOutput("wait_strobe_err", 32'(err_a), 32'd1);
        waitReadyA(1, low);
        checkOutput("wait_strobe_wait", 32'(low), 32'd3);
        checkOutput("wait_strobe_data", 32'(rd_data_a), 32'(sb.pop_front()));
        @(posedge clk); #1;
        checkOutput("err_sticky", 32'(err_a), 32'd1);

        // Reset while a read is pending aborts it.
        addr     = 16'h0123;
        rd_req_a = 1'b1;
        @(posedge clk); #1;
        rd_req_a = 1'b0;
        checkOutput("mid_wait_low", 32'(ready_a), 32'd0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("mid_rst_ready", 32'(ready_a), 32'd1);
        checkOutput("mid_rst_rd_data", 32'(rd_data_a), 32'h00);
        checkOutput("mid_rst_err", 32'(err_a), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("mid_rst_no_update", 32'(rd_data_a), 32'h00);
        readA(16'h0123, 8'h5A, "ram_preserved");

        // Backdoor load while not idle is dropped and flagged.
        addr     = 16'h0123;
        rd_req_a = 1'b1;
        sb.push_back(8'h5A);
        @(posedge clk); #1;
        rd_req_a  = 1'b0;
        load_addr = 16'h0123;
        load_data = 8'h00;
        load_en   = 1'b1;
        @(posedge clk); #1;
        load_en   = 1'b0;
        waitReadyA(2, low);
        checkOutput("busy_load_data", 32'(rd_data_a), 32'(sb.pop_front()));
        checkOutput("busy_load_err", 32'(err_a), 32'd1);
        readA(16'h0123, 8'h5A, "busy_load_dropped");

        // Zero-wait-state stream, one strobe per cycle.
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) begin
                addr     = 16'(k);
                rd_req_b = 1'b1;
                sb.push_back(8'(k * 17 + 3));
            end else begin
                rd_req_b = 1'b0;
            end
            @(posedge clk); #1;
            checkOutput($sformatf("stream_ready%0d", k), 32'(ready_b), 32'd1);
            if (k >= 1) begin
                exp_b = sb.pop_front();
                checkOutput($sformatf("stream_data%0d", k - 1), 32'(rd_data_b), 32'(exp_b));
            end
        end
        checkOutput("stream_err", 32'(err_b), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/m6502_mem_responder.md
# m6502_mem_responder

Memory-side responder for the m6502 CPU bus. It answers the CPU's `rd_req` and `wr_en` strobes with internal RAM, hardwired vector bytes and an open-bus value. It paces read transactions through `ready` with a programmable number of wait states. It sits between `m6502_cpu` and the system fabric, and also serves as the bench memory model for CPU verification.

## Interface
Parameters:
- `RAM_BITS`, 12: RAM size is 2^RAM_BITS bytes, mapped at $0000; legal range 8..15.
- `WAIT_STATES`, 1: extra cycles `ready` stays low per read; legal range 0..15.
- `RESET_VECTOR`, 16'hF000: returned at $FFFC (low byte) and $FFFD (high byte).
- `NMI_VECTOR`, 16'hF000: returned at $FFFA/$FFFB.
- `IRQ_VECTOR`, 16'hF000: returned at $FFFE/$FFFF.
- `OPEN_BUS`, 8'hFF: read value for unmapped addresses.

Ports:
- `clk`  in  1  single clock; all state changes on the posedge.
- `reset_n`  in  1  synchronous, active-low reset.
- `addr`  in  16  CPU address.
- `rd_req`  in  1  one-cycle read strobe.
- `wr_en`  in  1  one-cycle write strobe.
- `wr_data`  in  8  write data.
- `rd_data`  out  8  registered read data.
- `ready`  out  1  high when idle and able to accept a request, and when `rd_data` is valid.
- `err`  out  1  sticky protocol-error flag.
- `load_en`  in  1  backdoor RAM write, for boot load and bench use.
- `load_addr`  in  16  backdoor address.
- `load_data`  in  8  backdoor data.

## Operation
- Address map, first match wins:
  - `addr < 2^RAM_BITS`: RAM.
  - `addr >= $FFFA`: vector bytes, little-endian.
  - Otherwise: unmapped. Reads return `OPEN_BUS`; writes are dropped with no error.
- FSM states: IDLE, WAIT, RESP.
  - IDLE with `rd_req`=1:
    - Latch `addr` into `req_addr`.
    - If `WAIT_STATES`=0, go to RESP.
    - Otherwise load `wcnt`=`WAIT_STATES`, drive `ready`=0 and go to WAIT.
  - WAIT: decrement `wcnt` each cycle. At the cycle where `wcnt`=1, go to RESP.
  - RESP:
    - `rd_data` <= data at `req_addr`.
    - `ready` <= 1.
    - Return to IDLE in the same edge. RESP is a one-edge action state.
  - IDLE with `wr_en`=1: write `wr_data` to RAM at `addr` if mapped. Zero wait states; `ready` stays 1.
- `rd_data` holds its value until the next read completes. Writes never change `rd_data`.
- Protocol errors. Each sets `err`=1, which stays set until reset:
  - `rd_req` or `wr_en` while in WAIT. The strobe is ignored and the pending read completes unchanged.
  - `rd_req` and `wr_en` in the same cycle. The write is performed; the read is discarded and the FSM stays in IDLE.
- Backdoor load:
  - `load_en` writes RAM only when the FSM is in IDLE and no CPU strobe is present.
  - Otherwise the load is dropped and `err`=1.
  - Out-of-RAM `load_addr` is dropped silently.
- RAM is a single-port synchronous array. It is the sole storage and must infer block RAM: one write port, shared by CPU and backdoor; one registered read.

## Timing
- Reset values: `ready`=1, `rd_data`=8'h00, `err`=0, state IDLE, `wcnt`=0. RAM contents are preserved across reset.
- Reset mid-transaction: the pending read is aborted and no `rd_data` update occurs. `ready`=1 from the first edge with `reset_n`=0.
- Read latency: with `rd_req` sampled at edge N, `rd_data` is valid and `ready`=1 after edge N+WAIT_STATES+1.
  - `ready`=0 after edges N through N+WAIT_STATES.
  - With `WAIT_STATES`=0, `ready` never drops and data is valid after edge N+1.
- The CPU samples data on the first cycle with `ready`=1 and `rd_req`=0 following its request. `rd_data` must be stable from that point.
- Write: RAM updated at the sampling edge. A read of the same address sampled at edge N+1 returns the new value.
- Back-to-back reads: a new `rd_req` is accepted at the edge immediately after `ready` returns high.

## Test plan
- Reset vector, default params with `WAIT_STATES`=2:
  - Stimulus: release reset, read $FFFC then $FFFD.
  - Required: `ready` low for 3 cycles per read; `rd_data`=$00, then $F0.
- RAM write/read:
  - Stimulus: write $5A to $0123; read $0123 on the next cycle.
  - Required: $5A. Reading $0124 returns the backdoor-loaded value.
- Unmapped and mirror-free addresses:
  - Stimulus: write $77 to $8000, then read $8000.
  - Required: $FF, `err`=0.
  - Stimulus: read $1000 with `RAM_BITS`=12.
  - Required: $FF.
- Protocol errors:
  - Stimulus: `rd_req` during WAIT.
  - Required: original read completes with the correct data; `err`=1 and stays set.
  - Stimulus: simultaneous `rd_req`+`wr_en` to $0010 with data $33.
  - Required: RAM[$10]=$33, `ready` stays 1, `err`=1.
- Reset mid-wait:
  - Stimulus: assert `reset_n`=0 while in WAIT.
  - Required: `ready`=1 next edge, `rd_data`=$00, `err`=0; RAM data still readable afterwards.
- `WAIT_STATES`=0 stream:
  - Stimulus: 16 consecutive reads of $0000..$000F.
  - Required: `ready` constantly 1; each byte valid one cycle after its strobe.
